// File: rtl/clock_set_pkg.sv
// Shared constants for the clock/date set controller: state codes, field
// codes, per-field blink masks and small decode helpers.
package clock_set_pkg;

    localparam int unsigned FIELD_W = 3;
    localparam int unsigned MASK_W  = 6;
    localparam int unsigned TO_W    = 8;

    // FSM state encoding (binary)
    localparam logic [2:0] ST_RUN   = 3'd0;
    localparam logic [2:0] ST_HOUR  = 3'd1;
    localparam logic [2:0] ST_MIN   = 3'd2;
    localparam logic [2:0] ST_DAY   = 3'd3;
    localparam logic [2:0] ST_MONTH = 3'd4;
    localparam logic [2:0] ST_YEAR  = 3'd5;

    // Field codes presented to the timekeeping core
    localparam logic [FIELD_W-1:0] FLD_NONE  = 3'd0;
    localparam logic [FIELD_W-1:0] FLD_HOUR  = 3'd1;
    localparam logic [FIELD_W-1:0] FLD_MIN   = 3'd2;
    localparam logic [FIELD_W-1:0] FLD_DAY   = 3'd3;
    localparam logic [FIELD_W-1:0] FLD_MONTH = 3'd4;
    localparam logic [FIELD_W-1:0] FLD_YEAR  = 3'd5;

    // Digit-pair blink masks; bit0 is the leftmost digit
    localparam logic [MASK_W-1:0] MASK_LEFT  = 6'b000011;
    localparam logic [MASK_W-1:0] MASK_MID   = 6'b001100;
    localparam logic [MASK_W-1:0] MASK_RIGHT = 6'b110000;

    // True for every editing state
    function automatic logic is_set(input logic [2:0] st);
        return (st == ST_HOUR) || (st == ST_MIN) || (st == ST_DAY) ||
               (st == ST_MONTH) || (st == ST_YEAR);
    endfunction

    // Field code shown for a state
    function automatic logic [FIELD_W-1:0] field_of(input logic [2:0] st);
        case (st)
            ST_HOUR:  return FLD_HOUR;
            ST_MIN:   return FLD_MIN;
            ST_DAY:   return FLD_DAY;
            ST_MONTH: return FLD_MONTH;
            ST_YEAR:  return FLD_YEAR;
            default:  return FLD_NONE;
        endcase
    endfunction

    // Digit pair that blinks while a state is being edited
    function automatic logic [MASK_W-1:0] mask_of(input logic [2:0] st);
        case (st)
            ST_HOUR, ST_DAY:  return MASK_LEFT;
            ST_MIN, ST_MONTH: return MASK_MID;
            ST_YEAR:          return MASK_RIGHT;
            default:          return '0;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer followed by a stability
// counter. 'level' is the debounced button, 'press' a one-clk pulse on its
// rising edge. Raw edge to press latency is 2 + DEBOUNCE_CYC clks.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 20000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;

    // Synchronize, then accept a new level only after it held for DEBOUNCE_CYC clks
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 != r_level) begin
                if (r_cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
                    r_level <= r_sync2;
                    r_press <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign level = r_level;
    assign press = r_press;

endmodule

// File: rtl/clock_set_ctrl.sv
// Time/date set controller: turns the change/up/down buttons into field
// select, inc/dec and freeze commands for the timekeeping core, and drives
// the blink mask and time/date view select for the display.
// Optional macro CLOCK_SET_AUTO_REPEAT_EN: auto-repeat of a held up/down.
module clock_set_ctrl
    import clock_set_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = 20000,
    parameter int unsigned BLINK_CYC    = 25000,
    parameter int unsigned TIMEOUT_S    = 10
`ifdef CLOCK_SET_AUTO_REPEAT_EN
    ,
    parameter int unsigned RPT_DLY_CYC  = 50000,
    parameter int unsigned RPT_CYC      = 10000
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick_1s,
    input  logic               btn_change,
    input  logic               btn_up,
    input  logic               btn_down,
    output logic [FIELD_W-1:0] field,
    output logic               inc_pulse,
    output logic               dec_pulse,
    output logic               run_en,
    output logic               sec_clear,
    output logic               view_date,
    output logic [MASK_W-1:0]  blink_mask
);

    localparam int unsigned BL_W = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;

    logic              w_chg_press;
    logic              w_unused_chg_level;
    logic              w_up_press;
    logic              w_up_level;
    logic              w_dn_press;
    logic              w_dn_level;
    logic              w_up_ev;
    logic              w_dn_ev;

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic              w_in_set;
    logic              w_timeout;
    logic              w_up_acc;
    logic              w_dn_acc;
    logic              w_restart;

    logic [TO_W-1:0]   r_to_cnt;
    logic [BL_W-1:0]   r_blink_cnt;
    logic [BL_W-1:0]   w_blink_cnt_nxt;
    logic              r_phase;
    logic              w_phase_nxt;

    logic [FIELD_W-1:0] r_field;
    logic               r_inc;
    logic               r_dec;
    logic               r_run_en;
    logic               r_sec_clear;
    logic               r_view_date;
    logic [MASK_W-1:0]  r_blink_mask;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_change (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_change),
        .level   (w_unused_chg_level),
        .press   (w_chg_press)
    );

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_up (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_up),
        .level   (w_up_level),
        .press   (w_up_press)
    );

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_down (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_down),
        .level   (w_dn_level),
        .press   (w_dn_press)
    );

    assign w_in_set  = is_set(r_state);
    assign w_timeout = w_in_set && (r_to_cnt >= TO_W'(TIMEOUT_S));

`ifdef CLOCK_SET_AUTO_REPEAT_EN
    localparam int unsigned RPT_MAX = (RPT_DLY_CYC > RPT_CYC) ? RPT_DLY_CYC : RPT_CYC;
    localparam int unsigned RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

    logic [RPT_W-1:0] r_rpt_cnt;
    logic             r_rpt_first;
    logic             w_rpt_hold;
    logic             w_rpt_fire;

    // Exactly one of up/down held in an edit state; a fresh press restarts the delay
    assign w_rpt_hold = w_in_set && (w_up_level ^ w_dn_level) && !w_up_press && !w_dn_press;
    assign w_rpt_fire = w_rpt_hold &&
                        (r_rpt_first ? (r_rpt_cnt == RPT_W'(RPT_DLY_CYC - 1))
                                     : (r_rpt_cnt == RPT_W'(RPT_CYC - 1)));

    // Repeat timer: long first delay, then the shorter repeat interval
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rpt_cnt   <= '0;
            r_rpt_first <= 1'b1;
        end else if (!w_rpt_hold) begin
            r_rpt_cnt   <= '0;
            r_rpt_first <= 1'b1;
        end else if (w_rpt_fire) begin
            r_rpt_cnt   <= '0;
            r_rpt_first <= 1'b0;
        end else begin
            r_rpt_cnt <= r_rpt_cnt + RPT_W'(1);
        end
    end

    assign w_up_ev = w_up_press | (w_rpt_fire & w_up_level);
    assign w_dn_ev = w_dn_press | (w_rpt_fire & w_dn_level);
`else
    logic [1:0] w_unused_lvl;

    assign w_unused_lvl = {w_up_level, w_dn_level};
    assign w_up_ev      = w_up_press;
    assign w_dn_ev      = w_dn_press;
`endif

    // Next state and accepted up/down; change beats up/down and timeout
    always_comb begin
        w_state_nxt = r_state;
        w_up_acc    = 1'b0;
        w_dn_acc    = 1'b0;
        case (r_state)
            ST_RUN:   if (w_chg_press) w_state_nxt = ST_HOUR;
            ST_HOUR:  if (w_chg_press) w_state_nxt = ST_MIN;
                      else if (w_timeout) w_state_nxt = ST_RUN;
            ST_MIN:   if (w_chg_press) w_state_nxt = ST_DAY;
                      else if (w_timeout) w_state_nxt = ST_RUN;
            ST_DAY:   if (w_chg_press) w_state_nxt = ST_MONTH;
                      else if (w_timeout) w_state_nxt = ST_RUN;
            ST_MONTH: if (w_chg_press) w_state_nxt = ST_YEAR;
                      else if (w_timeout) w_state_nxt = ST_RUN;
            ST_YEAR:  if (w_chg_press || w_timeout) w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_RUN;
        endcase
        if (w_in_set && !w_chg_press && !w_timeout) begin
            w_up_acc = w_up_ev && !w_dn_ev;
            w_dn_acc = w_dn_ev && !w_up_ev;
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign w_restart = !is_set(w_state_nxt) || (w_state_nxt != r_state);

    // Inactivity timer in seconds; any accepted press or state change clears it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_to_cnt <= '0;
        end else if (w_restart || w_up_acc || w_dn_acc) begin
            r_to_cnt <= '0;
        end else if (tick_1s && (r_to_cnt != '1)) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end

    // Blink phase: restarts low on every state change, held low in RUN
    always_comb begin
        w_blink_cnt_nxt = r_blink_cnt + BL_W'(1);
        w_phase_nxt     = r_phase;
        if (w_restart) begin
            w_blink_cnt_nxt = '0;
            w_phase_nxt     = 1'b0;
        end else if (r_blink_cnt == BL_W'(BLINK_CYC - 1)) begin
            w_blink_cnt_nxt = '0;
            w_phase_nxt     = ~r_phase;
        end
    end

    // Blink counter and phase registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else begin
            r_blink_cnt <= w_blink_cnt_nxt;
            r_phase     <= w_phase_nxt;
        end
    end

    // Registered command and display outputs, aligned with the state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_field      <= FLD_NONE;
            r_inc        <= 1'b0;
            r_dec        <= 1'b0;
            r_run_en     <= 1'b1;
            r_sec_clear  <= 1'b0;
            r_view_date  <= 1'b0;
            r_blink_mask <= '0;
        end else begin
            r_field      <= field_of(w_state_nxt);
            r_inc        <= w_up_acc;
            r_dec        <= w_dn_acc;
            r_run_en     <= !((w_state_nxt == ST_HOUR) || (w_state_nxt == ST_MIN));
            r_sec_clear  <= (r_state == ST_MIN) && (w_state_nxt != ST_MIN);
            r_view_date  <= (w_state_nxt == ST_DAY) || (w_state_nxt == ST_MONTH) ||
                            (w_state_nxt == ST_YEAR);
            r_blink_mask <= w_phase_nxt ? mask_of(w_state_nxt) : '0;
        end
    end

    assign field      = r_field;
    assign inc_pulse  = r_inc;
    assign dec_pulse  = r_dec;
    assign run_en     = r_run_en;
    assign sec_clear  = r_sec_clear;
    assign view_date  = r_view_date;
    assign blink_mask = r_blink_mask;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl with shortened debounce/blink/repeat constants.
module tb_clock_set_ctrl;

    localparam int unsigned DEB  = 20;
    localparam int unsigned BLK  = 8;
    localparam int unsigned TOS  = 10;
    localparam int unsigned RDLY = 50;
    localparam int unsigned RCYC = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick_1s = 1'b0;
    logic       btn_change = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic [2:0] field;
    logic       inc_pulse;
    logic       dec_pulse;
    logic       run_en;
    logic       sec_clear;
    logic       view_date;
    logic [5:0] blink_mask;

    int n_pass  = 0;
    int n_total = 0;
    int n_inc   = 0;
    int n_dec   = 0;
    int n_sclr  = 0;
    int n_upprs = 0;

    typedef struct {
        logic  c, u, d;
        int    e_field, e_run, e_view, e_sclr, e_inc, e_dec;
        string name;
    } vec_t;

    vec_t vecs[11];

    clock_set_ctrl #(
        .DEBOUNCE_CYC (DEB),
        .BLINK_CYC    (BLK),
        .TIMEOUT_S    (TOS)
`ifdef CLOCK_SET_AUTO_REPEAT_EN
        ,
        .RPT_DLY_CYC  (RDLY),
        .RPT_CYC      (RCYC)
`endif
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tick_1s    (tick_1s),
        .btn_change (btn_change),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .field      (field),
        .inc_pulse  (inc_pulse),
        .dec_pulse  (dec_pulse),
        .run_en     (run_en),
        .sec_clear  (sec_clear),
        .view_date  (view_date),
        .blink_mask (blink_mask)
    );

    always #5 clk = ~clk;

    // Pulse counters, sampled 1 time unit after each active edge
    always @(posedge clk) begin
        #1;
        if (inc_pulse) n_inc++;
        if (dec_pulse) n_dec++;
        if (sec_clear) n_sclr++;
        if (dut.u_db_up.press) n_upprs++;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic drive(input logic c, input logic u, input logic d);
        btn_change = c;
        btn_up     = u;
        btn_down   = d;
    endtask

    // Drive buttons, return at the negedge after outputs react to the press
    task automatic press_start(input logic c, input logic u, input logic d);
        @(negedge clk);
        drive(c, u, d);
        repeat (DEB + 3) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic release_all();
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0);
        repeat (DEB + 4) @(negedge clk);
    endtask

    task automatic push(input logic c, input logic u, input logic d);
        press_start(c, u, d);
        release_all();
    endtask

    task automatic tick();
        @(negedge clk);
        tick_1s = 1'b1;
        @(negedge clk);
        tick_1s = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Nine ticks keep the edit state, the tenth drops to RUN one clk later
    task automatic run_timeout(input int fld, input int exp_sclr);
        for (int i = 0; i < int'(TOS) - 1; i++) tick();
        chk("to_before_last", int'(field), fld);
        @(negedge clk);
        tick_1s = 1'b1;
        @(negedge clk);
        tick_1s = 1'b0;
        chk("to_at_last_tick", int'(field), fld);
        @(negedge clk);
        chk("to_field", int'(field), 0);
        chk("to_run_en", int'(run_en), 1);
        chk("to_blink", int'(blink_mask), 0);
        chk("to_sec_clear", int'(sec_clear), exp_sclr);
    endtask

    int base_inc, base_dec, base_sclr, base_prs, t_seen, n_rpt;
    int rpt_t[$];

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1, 0, 0, 0, 0, 0, "chg_to_hour"};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 2, 0, 0, 0, 0, 0, "chg_to_min"};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 2, 0, 0, 0, 1, 0, "min_up1"};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 2, 0, 0, 0, 1, 0, "min_up2"};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 2, 0, 0, 0, 1, 0, "min_up3"};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 2, 0, 0, 0, 0, 1, "min_down"};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 2, 0, 0, 0, 0, 0, "min_up_down"};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 3, 1, 1, 1, 0, 0, "chg_to_day"};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 4, 1, 1, 0, 0, 0, "chg_to_month"};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 5, 1, 1, 0, 0, 0, "chg_to_year"};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 0, 1, 0, 0, 0, 0, "chg_to_run"};

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_field", int'(field), 0);
        chk("rst_inc", int'(inc_pulse), 0);
        chk("rst_dec", int'(dec_pulse), 0);
        chk("rst_run_en", int'(run_en), 1);
        chk("rst_sec_clear", int'(sec_clear), 0);
        chk("rst_view", int'(view_date), 0);
        chk("rst_blink", int'(blink_mask), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Bouncing up button in RUN: one press event, no inc
        base_prs = n_upprs;
        base_inc = n_inc;
        t_seen   = -1;
        btn_up = 1'b1; repeat (5) @(negedge clk);
        btn_up = 1'b0; repeat (5) @(negedge clk);
        btn_up = 1'b1; repeat (5) @(negedge clk);
        btn_up = 1'b0; repeat (5) @(negedge clk);
        btn_up = 1'b1;
        for (int k = 1; k <= int'(DEB) + 20; k++) begin
            @(negedge clk);
            if (dut.u_db_up.press && (t_seen < 0)) t_seen = k;
        end
        chk("bounce_latency", t_seen, int'(DEB) + 2);
        chk("bounce_press_cnt", n_upprs - base_prs, 1);
        chk("bounce_no_inc", n_inc - base_inc, 0);
        chk("bounce_field", int'(field), 0);
        release_all();

        // Table: field walk plus inc/dec in SET_MIN
        base_inc  = n_inc;
        base_dec  = n_dec;
        base_sclr = n_sclr;
        for (int i = 0; i < 11; i++) begin
            press_start(vecs[i].c, vecs[i].u, vecs[i].d);
            chk({vecs[i].name, "_field"}, int'(field), vecs[i].e_field);
            chk({vecs[i].name, "_run_en"}, int'(run_en), vecs[i].e_run);
            chk({vecs[i].name, "_view"}, int'(view_date), vecs[i].e_view);
            chk({vecs[i].name, "_sclr"}, int'(sec_clear), vecs[i].e_sclr);
            chk({vecs[i].name, "_inc"}, int'(inc_pulse), vecs[i].e_inc);
            chk({vecs[i].name, "_dec"}, int'(dec_pulse), vecs[i].e_dec);
            @(negedge clk);
            chk({vecs[i].name, "_inc_w1"}, int'(inc_pulse), 0);
            chk({vecs[i].name, "_dec_w1"}, int'(dec_pulse), 0);
            release_all();
        end
        chk("walk_inc_total", n_inc - base_inc, 3);
        chk("walk_dec_total", n_dec - base_dec, 1);
        chk("walk_sclr_total", n_sclr - base_sclr, 1);

        // SET_HOUR blink phase, then timeout back to RUN
        press_start(1'b1, 1'b0, 1'b0);
        chk("hour_blink_start", int'(blink_mask), 0);
        repeat (BLK - 1) @(negedge clk);
        chk("hour_blink_low_end", int'(blink_mask), 0);
        @(negedge clk);
        chk("hour_blink_on", int'(blink_mask), 6'b000011);
        repeat (BLK - 1) @(negedge clk);
        chk("hour_blink_high_end", int'(blink_mask), 6'b000011);
        @(negedge clk);
        chk("hour_blink_off", int'(blink_mask), 0);
        release_all();
        run_timeout(1, 0);

        // Timeout out of SET_MIN clears seconds
        push(1'b1, 1'b0, 1'b0);
        push(1'b1, 1'b0, 1'b0);
        chk("min_field", int'(field), 2);
        run_timeout(2, 1);

        // change + up together in SET_HOUR: change wins, no inc
        push(1'b1, 1'b0, 1'b0);
        base_inc = n_inc;
        base_dec = n_dec;
        press_start(1'b1, 1'b1, 1'b0);
        chk("coll_field", int'(field), 2);
        chk("coll_run_en", int'(run_en), 0);
        repeat (BLK) @(negedge clk);
        chk("min_blink_on", int'(blink_mask), 6'b001100);
        release_all();
        push(1'b0, 1'b1, 1'b1);
        chk("coll_inc_none", n_inc - base_inc, 0);
        chk("coll_dec_none", n_dec - base_dec, 0);
        chk("coll_min_field", int'(field), 2);

        // Async reset in SET_DAY while an inc is pending
        push(1'b1, 1'b0, 1'b0);
        chk("day_field", int'(field), 3);
        base_inc = n_inc;
        @(negedge clk);
        btn_up = 1'b1;
        repeat (DEB + 2) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_field", int'(field), 0);
        chk("arst_run_en", int'(run_en), 1);
        chk("arst_view", int'(view_date), 0);
        chk("arst_blink", int'(blink_mask), 0);
        chk("arst_inc", int'(inc_pulse), 0);
        btn_up = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (DEB + 5) @(negedge clk);
        chk("arst_inc_lost", n_inc - base_inc, 0);
        chk("arst_field_after", int'(field), 0);

        // Up held in SET_DAY
        push(1'b1, 1'b0, 1'b0);
        push(1'b1, 1'b0, 1'b0);
        push(1'b1, 1'b0, 1'b0);
        chk("hold_field", int'(field), 3);
        press_start(1'b0, 1'b1, 1'b0);
        chk("hold_first_inc", int'(inc_pulse), 1);
        rpt_t.delete();
        for (int k = 1; k <= 65; k++) begin
            @(negedge clk);
            if (inc_pulse) rpt_t.push_back(k);
        end
        n_rpt = rpt_t.size();
`ifdef CLOCK_SET_AUTO_REPEAT_EN
        chk("rpt_count", n_rpt, 2);
        if (n_rpt >= 2) begin
            chk("rpt_first_at", rpt_t[0], int'(RDLY));
            chk("rpt_second_at", rpt_t[1], int'(RDLY + RCYC));
        end
`else
        chk("hold_no_repeat", n_rpt, 0);
`endif
        release_all();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
